regfile_seq_ctrl: RTL and testbench
===================================

# regfile_seq_ctrl

Parametrised single-clock successor to the two-phase datapath controller. It accepts packed instructions over a valid/ready handshake and decodes them into one-hot register-file read and write enables, an ALU opcode and shift controls. It runs a two-stage read/write pipeline with write-to-read forwarding flags and multi-cycle shift sequencing. It sits between the instruction source and the bit-slice register file / ALU datapath.

## Interface
- `NREG`, default 4: number of registers; power of two, ≥2. Local `AW = $clog2(NREG)`; instruction width `IW = 3 + 2*AW`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_instr`  input  IW  `{op[2:0], rd[AW-1:0], ra[AW-1:0]}`; `rd` is both the B read address and the write address; `ra` is the A address, or the shift amount for shift ops.
- `in_valid`  input  1  instruction present.
- `in_ready`  output  1  controller can accept; transfer when `in_valid && in_ready`.
- `ARdEn`  output  NREG  one-hot A-port read enable.
- `BRdEn`  output  NREG  one-hot B-port read enable.
- `WriteEn`  output  NREG  one-hot write enable.
- `FBEn`  output  NREG  feedback (hold) enable, always `~WriteEn`.
- `alu_op`  output  3  opcode of the instruction in R stage.
- `a_zero`  output  1  force A operand to zero.
- `shl`, `shr`  output  1  single-bit shift left/right this R cycle.
- `fwd_a`, `fwd_b`  output  1  A/B operand must take the W-stage result instead of the register-file value.
- `busy`  output  1  any R or W stage occupied.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB, 110 SHL, 111 SHR.
- States: IDLE (no R work), RUN (R stage holds a single-cycle op), SHIFT (R stage iterating a shift); `cnt` is an AW-bit count of remaining iterations.
- Accepting a non-shift op:
  - Next cycle is its R cycle: `ARdEn[ra]=1`, `BRdEn[rd]=1`, `alu_op=op`.
  - `a_zero=1` only for PASSB.
  - Next state is RUN.
- Accepting SHL/SHR with `k=ra`:
  - If `k=0`: one R cycle, PASSB behaviour: `BRdEn[rd]`, `a_zero=1`, `shl=shr=0`, `ARdEn=0`.
  - If `k≥1`: state SHIFT, `cnt` loaded with `k-1`. Each R cycle asserts `BRdEn[rd]`, `a_zero=1`, `ARdEn=0`, and exactly one of `shl`/`shr`. `cnt` decrements each R cycle.
- Every R cycle is followed by exactly one W cycle with `WriteEn[rd]=1`.
- Outside R cycles, `ARdEn`, `BRdEn`, `alu_op`, `a_zero`, `shl` and `shr` are 0. Outside W cycles, `WriteEn=0`.
- `in_ready = !rst && !(state==SHIFT && cnt!=0)`. An instruction accepted in the last SHIFT R cycle (`cnt==0`) gets its R cycle immediately after, with no bubble.
- No accept and no remaining shift work → IDLE.
- Forwarding, evaluated per R cycle:
  - `fwd_a = ARdEn_active && W_valid && (ra == W_rd)`.
  - `fwd_b = BRdEn_active && W_valid && (rd == W_rd)`.
  - Shift iterations 2..k therefore have `fwd_b=1`.
- All enables, selects, forward flags and `alu_op` are registered outputs; `in_ready` is combinational from state.

## Timing
- Accept at edge E0 → R outputs in cycle after E0 → W outputs one cycle later. Latency to write is 2 cycles.
- Throughput: one non-shift instruction per cycle. A shift by `k≥1` occupies R for `k` cycles; a shift by 0 occupies it for 1.
- Back-to-back writes and reads of the same register resolve via forwarding; there are no stalls.
- While `rst`=1, and on the first cycle after it deasserts, outputs hold reset values: `ARdEn=BRdEn=WriteEn=0`, `FBEn` all ones, `alu_op=0`, `a_zero=shl=shr=fwd_a=fwd_b=busy=0`, state IDLE, `cnt=0`.
- `in_ready=0` while `rst`=1.
- Reset mid-shift or with a W cycle pending: the pending write is dropped. `WriteEn` is 0 from the cycle following the reset edge. No partial state survives.
- `in_valid` with `in_ready=0` has no effect; the source must hold the instruction.
- `FBEn` and `WriteEn` are never simultaneously 1 for the same bit.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid=1` → all enables 0, `FBEn=4'b1111`, `in_ready=0`, `busy=0`. The first cycle after release still has no enables asserted.
- ADD r1=r1+r2 (`op=000, rd=1, ra=2`) accepted at cycle 0:
  - Cycle 1: `ARdEn=0100`, `BRdEn=0010`, `alu_op=000`.
  - Cycle 2: `WriteEn=0010`, `FBEn=1101`.
- Back-to-back: `OR rd=3,ra=0`, then `XOR rd=2,ra=3` → second R cycle has `fwd_a=1`, `fwd_b=0`. Then `AND rd=2,ra=1` → `fwd_b=1`.
- SHL rd=2 by `k=3`:
  - `in_ready` low for 2 cycles; `shl=1`, `BRdEn=0100` for 3 R cycles.
  - `fwd_b` is 0,1,1 across the iterations; `WriteEn=0100` for 3 cycles.
  - A queued PASSB is accepted in the last iteration cycle with no bubble.
- SHR by 0 → single R cycle with `shr=0`, `a_zero=1`, `BRdEn[rd]`, then one write. `NREG=8` rerun: `IW=9`, `rd=7` gives one-hot `8'b1000_0000`.
- Reset asserted in second iteration of SHL by 3 → no `WriteEn` from the cycle after the reset edge, `cnt=0`, and `in_ready=1` on the first cycle after release.

Source files
------------

// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: decodes packed instructions into one-hot register-file
// read/write enables, ALU opcode and shift controls. Two-stage read (R) /
// write (W) pipeline with write-to-read forwarding flags and multi-cycle
// shift sequencing. All decoded outputs are registered; in_ready is
// combinational from the controller state.
module regfile_seq_ctrl #(
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG),
  localparam int IW   = 3 + 2*AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   in_instr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [NREG-1:0] ARdEn,
  output logic [NREG-1:0] BRdEn,
  output logic [NREG-1:0] WriteEn,
  output logic [NREG-1:0] FBEn,
  output logic [2:0]      alu_op,
  output logic            a_zero,
  output logic            shl,
  output logic            shr,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic            busy
);

  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_SHR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            r_valid_q, r_valid_d;
  logic [AW-1:0]   r_rd_q, r_rd_d;
  logic [NREG-1:0] ar_d, br_d, we_d;
  logic [2:0]      op_d;
  logic            az_d, shl_d, shr_d, fa_d, fb_d, busy_d;

  logic [2:0]      op_in;
  logic [AW-1:0]   rd_in;
  logic [AW-1:0]   ra_in;
  logic            accept;
  logic            is_shift;

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign op_in    = in_instr[IW-1 -: 3];
  assign rd_in    = in_instr[2*AW-1 -: AW];
  assign ra_in    = in_instr[AW-1:0];
  assign is_shift = (op_in == OP_SHL) || (op_in == OP_SHR);

  // Only a shift with iterations still to run blocks a new instruction.
  assign in_ready = !rst && !(state_q == SHIFT && cnt_q != '0);
  assign accept   = in_valid && in_ready;

  // The W stage always owns WriteEn; every other register holds its value.
  assign FBEn = ~WriteEn;

  // Next R-stage contents: a newly accepted instruction, the next shift
  // iteration, or nothing. The current R cycle moves into the W stage.
  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    r_valid_d = 1'b0;
    r_rd_d    = r_rd_q;
    ar_d      = '0;
    br_d      = '0;
    op_d      = '0;
    az_d      = 1'b0;
    shl_d     = 1'b0;
    shr_d     = 1'b0;
    fa_d      = 1'b0;
    fb_d      = 1'b0;
    we_d      = r_valid_q ? onehot(r_rd_q) : '0;

    if (accept) begin
      r_valid_d = 1'b1;
      r_rd_d    = rd_in;
      op_d      = op_in;
      br_d      = onehot(rd_in);
      fb_d      = r_valid_q && (rd_in == r_rd_q);
      if (is_shift) begin
        az_d = 1'b1;
        if (ra_in != '0) begin
          state_d = SHIFT;
          cnt_d   = ra_in - AW'(1);
          shl_d   = (op_in == OP_SHL);
          shr_d   = (op_in == OP_SHR);
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
        ar_d    = onehot(ra_in);
        az_d    = (op_in == OP_PASSB);
        fa_d    = r_valid_q && (ra_in == r_rd_q);
      end
    end else if (state_q == SHIFT && cnt_q != '0) begin
      state_d   = SHIFT;
      cnt_d     = cnt_q - AW'(1);
      r_valid_d = 1'b1;
      r_rd_d    = r_rd_q;
      op_d      = alu_op;
      br_d      = BRdEn;
      az_d      = 1'b1;
      shl_d     = shl;
      shr_d     = shr;
      fb_d      = r_valid_q;
    end

    busy_d = r_valid_d || r_valid_q;
  end

  // State, pipeline bookkeeping and registered outputs; reset drops any
  // pending shift iterations and writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_rd_q    <= '0;
      ARdEn     <= '0;
      BRdEn     <= '0;
      WriteEn   <= '0;
      alu_op    <= '0;
      a_zero    <= 1'b0;
      shl       <= 1'b0;
      shr       <= 1'b0;
      fwd_a     <= 1'b0;
      fwd_b     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_rd_q    <= r_rd_d;
      ARdEn     <= ar_d;
      BRdEn     <= br_d;
      WriteEn   <= we_d;
      alu_op    <= op_d;
      a_zero    <= az_d;
      shl       <= shl_d;
      shr       <= shr_d;
      fwd_a     <= fa_d;
      fwd_b     <= fb_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Testbench for regfile_seq_ctrl: NREG=4 instance checked through an
// expected-output scoreboard, plus a small NREG=8 instance.
module tb_regfile_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] in_instr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ARdEn, BRdEn, WriteEn, FBEn;
  logic [2:0] alu_op;
  logic       a_zero, shl, shr, fwd_a, fwd_b, busy;

  logic [8:0] in_instr8;
  logic       in_valid8;
  logic       in_ready8;
  logic [7:0] ARdEn8, BRdEn8, WriteEn8, FBEn8;
  logic [2:0] alu_op8;
  logic       a_zero8, shl8, shr8, fwd_a8, fwd_b8, busy8;

  logic [15:0] r_obs;
  logic [7:0]  w_obs;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic       fa;
    logic       fb;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [15:0] v;
  } exp_t;

  stim_t stim_q[$];
  exp_t  rq[$];
  exp_t  wq[$];

  regfile_seq_ctrl #(.NREG(4)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .ARdEn(ARdEn), .BRdEn(BRdEn), .WriteEn(WriteEn),
    .FBEn(FBEn), .alu_op(alu_op), .a_zero(a_zero), .shl(shl), .shr(shr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy)
  );

  regfile_seq_ctrl #(.NREG(8)) dut8 (
    .clk(clk), .rst(rst), .in_instr(in_instr8), .in_valid(in_valid8),
    .in_ready(in_ready8), .ARdEn(ARdEn8), .BRdEn(BRdEn8), .WriteEn(WriteEn8),
    .FBEn(FBEn8), .alu_op(alu_op8), .a_zero(a_zero8), .shl(shl8), .shr(shr8),
    .fwd_a(fwd_a8), .fwd_b(fwd_b8), .busy(busy8)
  );

  assign r_obs = {ARdEn, BRdEn, alu_op, a_zero, shl, shr, fwd_a, fwd_b};
  assign w_obs = {WriteEn, FBEn};

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index used to time-stamp scoreboard entries
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] oh4(input logic [1:0] i);
    logic [3:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Expand one accepted instruction into its expected R and W cycles.
  task automatic push_exp(input stim_t s, input int c);
    int   n;
    logic sh;
    exp_t e;
    sh = (s.op[2:1] == 2'b11);
    n  = (sh && s.ra != 2'd0) ? int'(s.ra) : 1;
    for (int i = 0; i < n; i++) begin
      e.cyc = c + i;
      if (sh)
        e.v = {4'b0000, oh4(s.rd), s.op, 1'b1, (s.ra != 2'd0) && !s.op[0],
               (s.ra != 2'd0) && s.op[0], 1'b0, (i == 0) ? s.fb : 1'b1};
      else
        e.v = {oh4(s.ra), oh4(s.rd), s.op, s.op == 3'b101, 2'b00, s.fa, s.fb};
      rq.push_back(e);
      e.cyc = c + 1 + i;
      e.v   = {8'h00, oh4(s.rd), ~oh4(s.rd)};
      wq.push_back(e);
    end
  endtask

  // Drive the head of the stimulus queue for one clock; push expectations on accept.
  task automatic applyStimulus(output logic rdy);
    logic  acc;
    stim_t s;
    if (stim_q.size() > 0 && stim_q[0].v) begin
      s        = stim_q[0];
      in_valid = 1'b1;
      in_instr = {s.op, s.rd, s.ra};
    end else begin
      in_valid = 1'b0;
      in_instr = 7'($urandom_range(0, 127));
    end
    rdy = in_ready;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (stim_q.size() > 0) begin
      if (!stim_q[0].v) s = stim_q.pop_front();
      else if (acc) begin
        s = stim_q.pop_front();
        push_exp(s, cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 7'b000_01_10;
    in_valid8 = 1'b1;
    in_instr8 = 9'b000_001_010;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (r_obs !== 16'h0 || w_obs !== 8'h0f || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cyc=%0d got r=%h w=%h busy=%b want r=0000 w=0f busy=0",
                 cyc, r_obs, w_obs, busy);
      end
      n_checks++;
      if (in_ready !== 1'b0 || in_ready8 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_ready got %b/%b want 0/0", in_ready, in_ready8);
      end
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (r_obs !== 16'h0 || w_obs !== 8'h0f || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL after_release got r=%h w=%h busy=%b rdy=%b want r=0000 w=0f busy=0 rdy=1",
               r_obs, w_obs, busy, in_ready);
    end
  endtask

  task automatic test_add();
    logic rdy, rh, wh;
    exp_t e;
    logic [15:0] er;
    logic [7:0]  ew;
    stim_q.push_back('{1'b1, 3'b000, 2'd1, 2'd2, 1'b0, 1'b0});
    for (int k = 0; k < 5; k++) begin
      applyStimulus(rdy);
      rh = rq.size() > 0 && rq[0].cyc == cyc;
      wh = wq.size() > 0 && wq[0].cyc == cyc;
      er = 16'h0;
      ew = 8'h0f;
      if (rh) begin e = rq.pop_front(); er = e.v; end
      if (wh) begin e = wq.pop_front(); ew = e.v[7:0]; end
      n_checks++;
      if (r_obs !== er || w_obs !== ew || busy !== (rh || wh)) begin
        n_fail++;
        $display("[TB] FAIL add cyc=%0d got r=%h w=%h busy=%b want r=%h w=%h busy=%b",
                 cyc, r_obs, w_obs, busy, er, ew, rh || wh);
      end
    end
    n_checks++;
    if (stim_q.size() != 0 || rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL add_drain got %0d/%0d/%0d left want 0/0/0", stim_q.size(), rq.size(), wq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, rh, wh;
    exp_t e;
    logic [15:0] er;
    logic [7:0]  ew;
    stim_q.push_back('{1'b1, 3'b011, 2'd3, 2'd0, 1'b0, 1'b0});
    stim_q.push_back('{1'b1, 3'b100, 2'd2, 2'd3, 1'b1, 1'b0});
    stim_q.push_back('{1'b1, 3'b010, 2'd2, 2'd1, 1'b0, 1'b1});
    stim_q.push_back('{1'b1, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0});
    for (int k = 0; k < 8; k++) begin
      applyStimulus(rdy);
      n_checks++;
      if (rdy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready k=%0d got %b want 1", k, rdy);
      end
      rh = rq.size() > 0 && rq[0].cyc == cyc;
      wh = wq.size() > 0 && wq[0].cyc == cyc;
      er = 16'h0;
      ew = 8'h0f;
      if (rh) begin e = rq.pop_front(); er = e.v; end
      if (wh) begin e = wq.pop_front(); ew = e.v[7:0]; end
      n_checks++;
      if (r_obs !== er || w_obs !== ew || busy !== (rh || wh)) begin
        n_fail++;
        $display("[TB] FAIL b2b cyc=%0d got r=%h w=%h busy=%b want r=%h w=%h busy=%b",
                 cyc, r_obs, w_obs, busy, er, ew, rh || wh);
      end
    end
    n_checks++;
    if (stim_q.size() != 0 || rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_drain got %0d/%0d/%0d left want 0/0/0", stim_q.size(), rq.size(), wq.size());
    end
  endtask

  task automatic test_shift();
    logic rdy, rh, wh;
    exp_t e;
    logic [15:0] er;
    logic [7:0]  ew;
    logic [8:0]  exp_rdy;
    exp_rdy = 9'b1_1111_1001;
    stim_q.push_back('{1'b1, 3'b110, 2'd2, 2'd3, 1'b0, 1'b0});
    stim_q.push_back('{1'b1, 3'b101, 2'd2, 2'd0, 1'b0, 1'b1});
    for (int k = 0; k < 9; k++) begin
      applyStimulus(rdy);
      n_checks++;
      if (rdy !== exp_rdy[k]) begin
        n_fail++;
        $display("[TB] FAIL shift_ready k=%0d got %b want %b", k, rdy, exp_rdy[k]);
      end
      rh = rq.size() > 0 && rq[0].cyc == cyc;
      wh = wq.size() > 0 && wq[0].cyc == cyc;
      er = 16'h0;
      ew = 8'h0f;
      if (rh) begin e = rq.pop_front(); er = e.v; end
      if (wh) begin e = wq.pop_front(); ew = e.v[7:0]; end
      n_checks++;
      if (r_obs !== er || w_obs !== ew || busy !== (rh || wh)) begin
        n_fail++;
        $display("[TB] FAIL shift cyc=%0d got r=%h w=%h busy=%b want r=%h w=%h busy=%b",
                 cyc, r_obs, w_obs, busy, er, ew, rh || wh);
      end
    end
    n_checks++;
    if (stim_q.size() != 0 || rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL shift_drain got %0d/%0d/%0d left want 0/0/0", stim_q.size(), rq.size(), wq.size());
    end
  endtask

  task automatic test_shift_short();
    logic rdy, rh, wh;
    exp_t e;
    logic [15:0] er;
    logic [7:0]  ew;
    stim_q.push_back('{1'b1, 3'b111, 2'd1, 2'd0, 1'b0, 1'b0});
    stim_q.push_back('{1'b1, 3'b110, 2'd0, 2'd1, 1'b0, 1'b0});
    stim_q.push_back('{1'b1, 3'b000, 2'd0, 2'd0, 1'b1, 1'b1});
    for (int k = 0; k < 7; k++) begin
      applyStimulus(rdy);
      n_checks++;
      if (rdy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL short_shift_ready k=%0d got %b want 1", k, rdy);
      end
      rh = rq.size() > 0 && rq[0].cyc == cyc;
      wh = wq.size() > 0 && wq[0].cyc == cyc;
      er = 16'h0;
      ew = 8'h0f;
      if (rh) begin e = rq.pop_front(); er = e.v; end
      if (wh) begin e = wq.pop_front(); ew = e.v[7:0]; end
      n_checks++;
      if (r_obs !== er || w_obs !== ew || busy !== (rh || wh)) begin
        n_fail++;
        $display("[TB] FAIL short_shift cyc=%0d got r=%h w=%h busy=%b want r=%h w=%h busy=%b",
                 cyc, r_obs, w_obs, busy, er, ew, rh || wh);
      end
    end
    n_checks++;
    if (stim_q.size() != 0 || rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL short_shift_drain got %0d/%0d/%0d left want 0/0/0", stim_q.size(), rq.size(), wq.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    logic rdy, rh, wh;
    exp_t e;
    logic [15:0] er;
    logic [7:0]  ew;
    stim_q.push_back('{1'b1, 3'b110, 2'd2, 2'd3, 1'b0, 1'b0});
    for (int k = 0; k < 2; k++) begin
      applyStimulus(rdy);
      rh = rq.size() > 0 && rq[0].cyc == cyc;
      wh = wq.size() > 0 && wq[0].cyc == cyc;
      er = 16'h0;
      ew = 8'h0f;
      if (rh) begin e = rq.pop_front(); er = e.v; end
      if (wh) begin e = wq.pop_front(); ew = e.v[7:0]; end
      n_checks++;
      if (r_obs !== er || w_obs !== ew) begin
        n_fail++;
        $display("[TB] FAIL pre_reset_shift cyc=%0d got r=%h w=%h want r=%h w=%h",
                 cyc, r_obs, w_obs, er, ew);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_ready got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    rq.delete();
    wq.delete();
    n_checks++;
    if (r_obs !== 16'h0 || w_obs !== 8'h0f || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs got r=%h w=%h busy=%b want r=0000 w=0f busy=0",
               r_obs, w_obs, busy);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || r_obs !== 16'h0 || w_obs !== 8'h0f || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL post_reset k=%0d got rdy=%b r=%h w=%h busy=%b want rdy=1 r=0000 w=0f busy=0",
                 k, in_ready, r_obs, w_obs, busy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_nreg8();
    n_checks++;
    if (in_ready8 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL n8_ready got %b want 1", in_ready8);
    end
    in_instr8 = {3'b111, 3'd7, 3'd0};
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n_checks++;
    if (BRdEn8 !== 8'b1000_0000 || ARdEn8 !== 8'h00 || a_zero8 !== 1'b1 ||
        shr8 !== 1'b0 || shl8 !== 1'b0 || WriteEn8 !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL n8_shr0_r got b=%h a=%h az=%b shr=%b shl=%b we=%h want b=80 a=00 az=1 shr=0 shl=0 we=00",
               BRdEn8, ARdEn8, a_zero8, shr8, shl8, WriteEn8);
    end
    in_instr8 = {3'b000, 3'd5, 3'd6};
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n_checks++;
    if (WriteEn8 !== 8'b1000_0000 || FBEn8 !== 8'b0111_1111) begin
      n_fail++;
      $display("[TB] FAIL n8_shr0_w got we=%h fb=%h want we=80 fb=7f", WriteEn8, FBEn8);
    end
    n_checks++;
    if (ARdEn8 !== 8'h40 || BRdEn8 !== 8'h20 || alu_op8 !== 3'b000 || fwd_a8 !== 1'b0 || fwd_b8 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL n8_add_r got a=%h b=%h op=%b fa=%b fb=%b want a=40 b=20 op=000 fa=0 fb=0",
               ARdEn8, BRdEn8, alu_op8, fwd_a8, fwd_b8);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (WriteEn8 !== 8'h20 || BRdEn8 !== 8'h00 || busy8 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL n8_add_w got we=%h b=%h busy=%b want we=20 b=00 busy=1", WriteEn8, BRdEn8, busy8);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (WriteEn8 !== 8'h00 || busy8 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL n8_idle got we=%h busy=%b want we=00 busy=0", WriteEn8, busy8);
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] regfile_seq_ctrl bench start");
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_shift_short();
    test_reset_mid_shift();
    test_nreg8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
